// File: rtl/sample_port_arbiter.sv
// rtl/sample_port_arbiter.sv - two-client read/write arbiter onto an Avalon-MM master with quantum fairness
// Optional statistics counters are built when ARB_STATS_EN is defined.
module sample_port_arbiter #(
    parameter int MAX_OUTSTANDING = 4,
    parameter int QUANTUM         = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        r_req,
    input  logic [23:0] r_addr,
    output logic        r_ack,
    output logic [31:0] r_data,
    output logic        r_valid,
    input  logic        w_req,
    input  logic [23:0] w_addr,
    input  logic [31:0] w_data,
    output logic        w_ack,
    output logic [23:0] sdaddress,
    output logic        sdread,
    output logic        sdwrite,
    output logic [31:0] sdwritedata,
    input  logic [31:0] sdreaddata,
    input  logic        sdreaddatavalid,
    input  logic        sdwaitrequest,
    output logic [2:0]  outstanding,
    input  logic        stat_clr,
    output logic [31:0] stat_rd_count,
    output logic [31:0] stat_wr_count
);

    typedef enum logic [1:0] {IDLE, OWN_RD, OWN_WR} state_t;

    state_t      state_q, state_d;
    logic [7:0]  qcnt_q, qcnt_d;
    logic        cmd_valid_q, cmd_valid_d;
    logic [23:0] sdaddress_q, sdaddress_d;
    logic        sdread_q, sdread_d;
    logic        sdwrite_q, sdwrite_d;
    logic [31:0] sdwritedata_q, sdwritedata_d;
    logic [2:0]  outstanding_q, outstanding_d;
    logic        r_valid_q, r_valid_d;
    logic [31:0] r_data_q, r_data_d;

    logic load_opp, r_elig, w_elig, grant_r, grant_w;

    always_comb begin
        load_opp = !cmd_valid_q || !sdwaitrequest;
        r_elig   = r_req && (outstanding_q < 3'(MAX_OUTSTANDING));
        w_elig   = w_req;
        grant_r  = 1'b0;
        grant_w  = 1'b0;
        state_d  = state_q;
        qcnt_d   = qcnt_q;

        if (load_opp) begin
            unique case (state_q)
                IDLE: begin
                    if (r_elig)      grant_r = 1'b1;
                    else if (w_elig) grant_w = 1'b1;
                end
                OWN_RD: begin
                    if (r_elig && (!w_elig || qcnt_q < 8'(QUANTUM))) grant_r = 1'b1;
                    else if (w_elig)                                  grant_w = 1'b1;
                end
                OWN_WR: begin
                    if (w_elig && (!r_elig || qcnt_q < 8'(QUANTUM))) grant_w = 1'b1;
                    else if (r_elig)                                  grant_r = 1'b1;
                end
                default: state_d = IDLE;
            endcase

            // A new owner's first load counts as one; an idle owner forfeits its count.
            if (grant_r) begin
                state_d = OWN_RD;
                qcnt_d  = (state_q == OWN_RD) ? ((qcnt_q == 8'hFF) ? qcnt_q : qcnt_q + 8'd1) : 8'd1;
            end else if (grant_w) begin
                state_d = OWN_WR;
                qcnt_d  = (state_q == OWN_WR) ? ((qcnt_q == 8'hFF) ? qcnt_q : qcnt_q + 8'd1) : 8'd1;
            end else begin
                qcnt_d = 8'd0;
                if (!cmd_valid_q) state_d = IDLE;
            end
        end

        r_ack = grant_r;
        w_ack = grant_w;
    end

    always_comb begin
        cmd_valid_d   = cmd_valid_q;
        sdaddress_d   = sdaddress_q;
        sdread_d      = sdread_q;
        sdwrite_d     = sdwrite_q;
        sdwritedata_d = sdwritedata_q;
        if (grant_r) begin
            cmd_valid_d = 1'b1;
            sdaddress_d = r_addr;
            sdread_d    = 1'b1;
            sdwrite_d   = 1'b0;
        end else if (grant_w) begin
            cmd_valid_d   = 1'b1;
            sdaddress_d   = w_addr;
            sdread_d      = 1'b0;
            sdwrite_d     = 1'b1;
            sdwritedata_d = w_data;
        end else if (load_opp) begin
            cmd_valid_d = 1'b0;
            sdread_d    = 1'b0;
            sdwrite_d   = 1'b0;
        end

        // Returns after a reset have no matching load, so the count floors at zero.
        outstanding_d = outstanding_q;
        if (grant_r && !sdreaddatavalid)
            outstanding_d = outstanding_q + 3'd1;
        else if (!grant_r && sdreaddatavalid && outstanding_q != 3'd0)
            outstanding_d = outstanding_q - 3'd1;

        r_valid_d = sdreaddatavalid;
        r_data_d  = sdreaddata;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            qcnt_q        <= 8'd0;
            cmd_valid_q   <= 1'b0;
            sdaddress_q   <= 24'd0;
            sdread_q      <= 1'b0;
            sdwrite_q     <= 1'b0;
            sdwritedata_q <= 32'd0;
            outstanding_q <= 3'd0;
            r_valid_q     <= 1'b0;
            r_data_q      <= 32'd0;
        end else begin
            state_q       <= state_d;
            qcnt_q        <= qcnt_d;
            cmd_valid_q   <= cmd_valid_d;
            sdaddress_q   <= sdaddress_d;
            sdread_q      <= sdread_d;
            sdwrite_q     <= sdwrite_d;
            sdwritedata_q <= sdwritedata_d;
            outstanding_q <= outstanding_d;
            r_valid_q     <= r_valid_d;
            r_data_q      <= r_data_d;
        end
    end

    assign sdaddress   = sdaddress_q;
    assign sdread      = sdread_q;
    assign sdwrite     = sdwrite_q;
    assign sdwritedata = sdwritedata_q;
    assign outstanding = outstanding_q;
    assign r_valid     = r_valid_q;
    assign r_data      = r_data_q;

`ifdef ARB_STATS_EN
    logic [31:0] stat_rd_q, stat_rd_d, stat_wr_q, stat_wr_d;
    logic        acc_rd, acc_wr;

    always_comb begin
        acc_rd    = cmd_valid_q && !sdwaitrequest && sdread_q;
        acc_wr    = cmd_valid_q && !sdwaitrequest && sdwrite_q;
        stat_rd_d = stat_rd_q;
        stat_wr_d = stat_wr_q;
        if (stat_clr) begin
            stat_rd_d = 32'd0;
            stat_wr_d = 32'd0;
        end else begin
            if (acc_rd && stat_rd_q != 32'hFFFF_FFFF) stat_rd_d = stat_rd_q + 32'd1;
            if (acc_wr && stat_wr_q != 32'hFFFF_FFFF) stat_wr_d = stat_wr_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stat_rd_q <= 32'd0;
            stat_wr_q <= 32'd0;
        end else begin
            stat_rd_q <= stat_rd_d;
            stat_wr_q <= stat_wr_d;
        end
    end

    assign stat_rd_count = stat_rd_q;
    assign stat_wr_count = stat_wr_q;
`else
    logic stat_clr_unused;
    assign stat_clr_unused = stat_clr;
    assign stat_rd_count   = 32'd0;
    assign stat_wr_count   = 32'd0;
`endif

endmodule

// File: doc/sample_port_arbiter.md
SAMPLE_PORT_ARBITER -- requirements
Module: sample_port_arbiter

Interface
REQ-001 SHALL have parameter MAX_OUTSTANDING, default 4, maximum reads loaded but not yet returned (range 1..7).
REQ-002 SHALL have parameter QUANTUM, default 8, consecutive loads granted to one client while the other waits (range 1..255).
REQ-003 clk  in  1  sole clock, all state on rising edge.
REQ-004 reset_n  in  1  asynchronous active-low reset.
REQ-005 r_req  in  1  read client request, held with r_addr until r_ack.
REQ-006 r_addr  in  24  read byte address.
REQ-007 r_ack  out  1  combinational pulse: read request loaded this cycle.
REQ-008 r_data  out  32  returned read data.
REQ-009 r_valid  out  1  r_data valid strobe.
REQ-010 w_req  in  1  write client request, held with w_addr/w_data until w_ack.
REQ-011 w_addr  in  24  write byte address.
REQ-012 w_data  in  32  write data.
REQ-013 w_ack  out  1  combinational pulse: write request loaded this cycle.
REQ-014 sdaddress  out  24; sdread  out  1; sdwrite  out  1; sdwritedata  out  32: Avalon-MM master command, all registered.
REQ-015 sdreaddata  in  32; sdreaddatavalid  in  1; sdwaitrequest  in  1: Avalon-MM master response.
REQ-016 outstanding  out  3  current outstanding-read count.
REQ-017 stat_clr  in  1; stat_rd_count  out  32; stat_wr_count  out  32: statistics (see Configuration).

Function
REQ-018 Command register (cmd_valid, address, rd/wr, data) SHALL load when !cmd_valid or the current command is accepted (cmd_valid && !sdwaitrequest), giving 1 command/cycle sustained.
REQ-019 While cmd_valid && sdwaitrequest, sdaddress/sdread/sdwrite/sdwritedata SHALL hold stable.
REQ-020 Read client eligible only when r_req && outstanding < MAX_OUTSTANDING; write client eligible when w_req.
REQ-021 Arbiter states: IDLE, OWN_RD, OWN_WR; at a load opportunity with one eligible client, that client loads and becomes owner.
REQ-022 Both eligible: owner loads until quantum counter reaches QUANTUM, then the other client loads, ownership switches, counter restarts at 1.
REQ-023 Quantum counter SHALL reset to 0 whenever the owner has no eligible request at a load opportunity; state returns to IDLE when neither is eligible and cmd_valid is low.
REQ-024 IDLE with both eligible SHALL grant the read client.
REQ-025 outstanding SHALL increment on read load, decrement on sdreaddatavalid, stay unchanged when both occur, and never underflow below 0.
REQ-026 r_valid/r_data SHALL be sdreaddatavalid/sdreaddata registered, latency exactly 1 cycle.
REQ-027 When no command is loaded and the held command is accepted, sdread/sdwrite SHALL be 0 the following cycle.

Reset
REQ-028 reset_n low SHALL immediately clear cmd_valid, sdread, sdwrite, sdaddress, sdwritedata, r_valid, r_data, outstanding, quantum counter, statistics, and set state IDLE.
REQ-029 Reset mid-transfer SHALL abandon in-flight reads; sdreaddatavalid arriving after reset SHALL still drive r_valid but leave outstanding at 0.

Configuration
REQ-030 With ARB_STATS_EN defined, stat_rd_count/stat_wr_count SHALL increment on each accepted read/write, saturate at 0xFFFFFFFF, and clear synchronously on stat_clr (clear wins over increment).
REQ-031 Without ARB_STATS_EN, stat_rd_count/stat_wr_count SHALL be constant 0 and stat_clr ignored; no counter logic.

Verification
REQ-032 Read only, waitrequest low, r_req held 6 cycles, no readdatavalid -> 4 r_ack pulses then stall, outstanding=4; one sdreaddatavalid -> 5th load next cycle.
REQ-033 Both req continuous, QUANTUM=2, MAX_OUTSTANDING=7, responses returned -> load order R,R,W,W,R,R,W,W.
REQ-034 Write to 0x000100 data 0xDEADBEEF, sdwaitrequest high 3 cycles -> command stable 4 cycles, single w_ack, sdwrite drops after acceptance.
REQ-035 sdreaddatavalid with sdreaddata=0x12345678 -> r_valid=1, r_data=0x12345678 exactly 1 cycle later; simultaneous load+return leaves outstanding unchanged.
REQ-036 reset_n pulsed low with outstanding=3, then 3 sdreaddatavalid -> outputs zero during reset, 3 r_valid pulses, outstanding stays 0.
REQ-037 ARB_STATS_EN: 5 reads, 2 writes accepted -> stat_rd_count=5, stat_wr_count=2; stat_clr with concurrent accept -> both 0.
